// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: two-to-one I/D-cache line arbiter in front of the burst cacheline adaptor.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating I/D priority; default is fixed D-over-I priority.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,
    output logic [ADDR_W-1:0] a_address_o,
    output logic [LINE_W-1:0] a_line_o,
    output logic              a_read_o,
    output logic              a_write_o,
    input  logic [LINE_W-1:0] a_line_i,
    input  logic              a_resp_i,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_RD_BUSY, D_WR_BUSY} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    state_t            state, state_n;
    logic [7:0]        cnt;
    logic              err_q, busy, grant, i_first, d_rd_done;
    logic [LINE_W-1:0] i_line_q, d_line_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign i_first = last_d;
    // remember which side won last so the other side wins the next tie
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last_d <= 1'b0;
        else if (grant) last_d <= (state_n != I_BUSY);
`else
    assign i_first = 1'b0;
`endif
    assign busy = state != IDLE;
    // next state: grant from IDLE by priority (D write over D read), back to IDLE on adaptor completion
    always_comb begin
        state_n = state;
        if (!busy) begin
            if ((d_read_i || d_write_i) && !(i_read_i && i_first)) state_n = d_write_i ? D_WR_BUSY : D_RD_BUSY;
            else if (i_read_i) state_n = I_BUSY;
        end else if (a_resp_i) state_n = IDLE;
    end
    assign grant     = !busy && state_n != IDLE;
    assign a_read_o  = state == I_BUSY || state == D_RD_BUSY;
    assign a_write_o = state == D_WR_BUSY;
    assign i_resp_o  = state == I_BUSY && a_resp_i;
    assign d_rd_done = state == D_RD_BUSY && a_resp_i;
    assign d_resp_o  = d_rd_done || (a_write_o && a_resp_i);
    assign i_line_o  = i_resp_o ? a_line_i : i_line_q;
    assign d_line_o  = d_rd_done ? a_line_i : d_line_q;
    assign err_o     = err_q;
    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    // latch the winner's address (and writeback line) so later requester changes cannot reach the adaptor
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            a_address_o <= '0;
            a_line_o    <= '0;
        end else if (grant) begin
            a_address_o <= state_n == I_BUSY ? i_address_i : d_address_i;
            if (state_n == D_WR_BUSY) a_line_o <= d_line_i;
        end
    // hold each port's last read line between completions
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            i_line_q <= '0;
            d_line_q <= '0;
        end else begin
            if (i_resp_o) i_line_q <= a_line_i;
            if (d_rd_done) d_line_q <= a_line_i;
        end
    // busy-cycle watchdog: saturating count, sticky error once the limit is reached
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (grant) cnt <= '0;
        else if (busy && !a_resp_i) begin
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (cnt == TO_LAST) err_q <= 1'b1;
        end
endmodule
